// File: rtl/rs_mon.sv
// RS flip-flop monitor: synchronizes a Q/_Q pair, validates it, and
// reports state, edge pulses, a rise counter and sticky fault flags.
module rs_mon (
    input  logic       Cp,
    input  logic       _CLR,
    input  logic       Q,
    input  logic       _Q,
    input  logic       CntClr,
    output logic       Qs,
    output logic       Rise,
    output logic       Fall,
    output logic [3:0] Cnt,
    output logic       Ovf,
    output logic       Fault
);

    typedef enum logic [1:0] {
        LOW  = 2'd0,
        HIGH = 2'd1,
        BAD  = 2'd2
    } state_e;

    logic [1:0] s1_q;
    logic [1:0] s2_q;
    state_e     state_q;
    state_e     state_d;
    logic       inv_p_q;
    logic       inv_p_d;
    logic       bv_q;
    logic       bv_d;
    logic       qs_q;
    logic       qs_d;
    logic       rise_q;
    logic       rise_d;
    logic       fall_q;
    logic       fall_d;
    logic       fault_q;
    logic       fault_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       ovf_q;
    logic       ovf_d;

    logic vh;
    logic vl;
    logic inv;

    assign vh  = (s2_q == 2'b10);
    assign vl  = (s2_q == 2'b01);
    assign inv = ~(vh | vl);

    always_ff @(posedge Cp) begin
        if (!_CLR) begin
            s1_q <= 2'b01;
            s2_q <= 2'b01;
        end else begin
            s1_q <= {Q, _Q};
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge Cp) begin
        if (!_CLR) begin
            state_q <= LOW;
            inv_p_q <= 1'b0;
            bv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            inv_p_q <= inv_p_d;
            bv_q    <= bv_d;
        end
    end

    // bv_q marks one valid pair already seen while in BAD
    always_comb begin
        state_d = state_q;
        inv_p_d = inv;
        bv_d    = 1'b0;
        case (state_q)
            LOW: begin
                if (vh)
                    state_d = HIGH;
                else if (inv && inv_p_q)
                    state_d = BAD;
            end
            HIGH: begin
                if (vl)
                    state_d = LOW;
                else if (inv && inv_p_q)
                    state_d = BAD;
            end
            BAD: begin
                if (!inv) begin
                    if (bv_q)
                        state_d = vh ? HIGH : LOW;
                    else
                        bv_d = 1'b1;
                end
            end
            default: state_d = LOW;
        endcase
    end

    always_comb begin
        rise_d  = (state_q == LOW) && vh;
        fall_d  = (state_q == HIGH) && vl;
        fault_d = fault_q
                | ((state_q != BAD) && (state_d == BAD));
        qs_d    = qs_q;
        if (state_d == HIGH)
            qs_d = 1'b1;
        else if (state_d == LOW)
            qs_d = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (rise_d) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'hf)
                ovf_d = 1'b1;
        end
        if (CntClr) begin
            cnt_d = {3'b000, rise_d};
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge Cp) begin
        if (!_CLR) begin
            qs_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= 4'd0;
            ovf_q   <= 1'b0;
        end else begin
            qs_q    <= qs_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Qs    = qs_q;
    assign Rise  = rise_q;
    assign Fall  = fall_q;
    assign Cnt   = cnt_q;
    assign Ovf   = ovf_q;
    assign Fault = fault_q;

endmodule

// File: tb/tb_rs_mon.sv
// Directed bench for rs_mon: latency, pulses, skew tolerance,
// fault recovery, counter wrap and reset priority.
module tb_rs_mon;

    logic       Cp = 1'b0;
    logic       _CLR;
    logic       Q;
    logic       _Q;
    logic       CntClr;
    logic       Qs;
    logic       Rise;
    logic       Fall;
    logic [3:0] Cnt;
    logic       Ovf;
    logic       Fault;

    int n_chk = 0;
    int n_err = 0;

    rs_mon dut (
        .Cp     (Cp),
        ._CLR   (_CLR),
        .Q      (Q),
        ._Q     (_Q),
        .CntClr (CntClr),
        .Qs     (Qs),
        .Rise   (Rise),
        .Fall   (Fall),
        .Cnt    (Cnt),
        .Ovf    (Ovf),
        .Fault  (Fault)
    );

    always #5 Cp = ~Cp;

    task automatic chk(input string tag,
                       input logic [3:0] act,
                       input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Cp);
            #1;
        end
    endtask

    task automatic drive(input logic q, input logic qn);
        Q  = q;
        _Q = qn;
    endtask

    task automatic chk_all0(input string tag);
        chk({tag, ".Qs"},    {3'b0, Qs},    4'd0);
        chk({tag, ".Rise"},  {3'b0, Rise},  4'd0);
        chk({tag, ".Fall"},  {3'b0, Fall},  4'd0);
        chk({tag, ".Cnt"},   Cnt,           4'd0);
        chk({tag, ".Ovf"},   {3'b0, Ovf},   4'd0);
        chk({tag, ".Fault"}, {3'b0, Fault}, 4'd0);
    endtask

    int rises;

    initial begin
        _CLR   = 1'b0;
        CntClr = 1'b0;
        drive(1'b0, 1'b1);
        tick(3);
        chk_all0("reset");

        // first rise: E1, E2 quiet, pulse between E3 and E4
        _CLR = 1'b1;
        drive(1'b1, 1'b0);
        tick(1);
        chk("r.E1.Rise", {3'b0, Rise}, 4'd0);
        tick(1);
        chk("r.E2.Rise", {3'b0, Rise}, 4'd0);
        chk("r.E2.Qs",   {3'b0, Qs},   4'd0);
        tick(1);
        chk("r.E3.Rise", {3'b0, Rise}, 4'd1);
        chk("r.E3.Qs",   {3'b0, Qs},   4'd1);
        chk("r.E3.Cnt",  Cnt,          4'd1);
        tick(1);
        chk("r.E4.Rise", {3'b0, Rise}, 4'd0);
        chk("r.E4.Qs",   {3'b0, Qs},   4'd1);

        // fall from HIGH
        drive(1'b0, 1'b1);
        tick(2);
        chk("f.E2.Fall", {3'b0, Fall}, 4'd0);
        tick(1);
        chk("f.E3.Fall", {3'b0, Fall}, 4'd1);
        chk("f.E3.Rise", {3'b0, Rise}, 4'd0);
        chk("f.E3.Qs",   {3'b0, Qs},   4'd0);
        chk("f.E3.Cnt",  Cnt,          4'd1);
        tick(1);
        chk("f.E4.Fall", {3'b0, Fall}, 4'd0);

        // one-cycle invalid pair is tolerated
        drive(1'b1, 1'b1);
        tick(1);
        drive(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("skew.Fault", {3'b0, Fault},       4'd0);
            chk("skew.Pulse", {2'b0, Rise, Fall},  4'd0);
        end

        // persistent invalid pair -> BAD
        drive(1'b1, 1'b1);
        tick(6);
        chk("bad.Fault", {3'b0, Fault}, 4'd1);
        chk("bad.Qs",    {3'b0, Qs},    4'd0);

        // leave BAD to HIGH without a Rise
        drive(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("exit.Rise",  {3'b0, Rise},  4'd0);
            chk("exit.Fault", {3'b0, Fault}, 4'd1);
        end
        chk("exit.Qs",  {3'b0, Qs}, 4'd1);
        chk("exit.Cnt", Cnt,        4'd1);

        CntClr = 1'b1;
        tick(1);
        CntClr = 1'b0;
        chk("clr.Cnt",   Cnt,           4'd0);
        chk("clr.Ovf",   {3'b0, Ovf},   4'd0);
        chk("clr.Fault", {3'b0, Fault}, 4'd1);

        drive(1'b0, 1'b1);
        tick(4);
        rises = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0);
            for (int k = 0; k < 4; k++) begin
                tick(1);
                if (Rise) rises++;
            end
            if (i == 14) begin
                chk("wrap15.Cnt", Cnt,         4'd15);
                chk("wrap15.Ovf", {3'b0, Ovf}, 4'd0);
            end
            drive(1'b0, 1'b1);
            tick(4);
        end
        chk("wrap.Rises", rises[3:0] ^ 4'(rises >> 4), 4'd1);
        chk("wrap.Cnt",   Cnt,         4'd0);
        chk("wrap.Ovf",   {3'b0, Ovf}, 4'd1);

        // CntClr coincident with a Rise
        drive(1'b1, 1'b0);
        tick(2);
        CntClr = 1'b1;
        tick(1);
        CntClr = 1'b0;
        chk("coin.Rise", {3'b0, Rise}, 4'd1);
        chk("coin.Cnt",  Cnt,          4'd1);
        chk("coin.Ovf",  {3'b0, Ovf},  4'd0);

        // bring Cnt to 5, reset while the fifth Rise is high
        tick(1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1);
            tick(4);
            drive(1'b1, 1'b0);
            tick(3);
            if (i != 3) tick(1);
        end
        chk("pre.Rise",  {3'b0, Rise},  4'd1);
        chk("pre.Cnt",   Cnt,           4'd5);
        chk("pre.Fault", {3'b0, Fault}, 4'd1);
        chk("pre.Qs",    {3'b0, Qs},    4'd1);
        _CLR   = 1'b0;
        CntClr = 1'b0;
        tick(1);
        chk_all0("midrst");

        // input held at (1,0) through reset release
        _CLR = 1'b1;
        tick(2);
        chk("rel.E2.Rise", {3'b0, Rise}, 4'd0);
        tick(1);
        chk("rel.E3.Rise", {3'b0, Rise}, 4'd1);
        chk("rel.E3.Cnt",  Cnt,          4'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rs_mon.md
RS_MON -- requirements
Module: rs_mon

Interface
REQ-001 The block SHALL have the port Cp, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port _CLR, input, 1 bit: synchronous active-low reset, sampled on the rising edge of Cp.
REQ-003 The block SHALL have the port Q, input, 1 bit: true output of the upstream RS flip-flop, asynchronous to Cp.
REQ-004 The block SHALL have the port _Q, input, 1 bit: complement output of the upstream RS flip-flop, asynchronous to Cp.
REQ-005 The block SHALL have the port CntClr, input, 1 bit: synchronous clear of Cnt and Ovf.
REQ-006 The block SHALL have the port Qs, output, 1 bit: synchronized, validated flip-flop state.
REQ-007 The block SHALL have the port Rise, output, 1 bit: one-cycle pulse on a validated 0->1 transition.
REQ-008 The block SHALL have the port Fall, output, 1 bit: one-cycle pulse on a validated 1->0 transition.
REQ-009 The block SHALL have the port Cnt, output, 4 bits: count of Rise pulses.
REQ-010 The block SHALL have the port Ovf, output, 1 bit: sticky flag, Cnt wrapped 15->0.
REQ-011 The block SHALL have the port Fault, output, 1 bit: sticky flag, an invalid Q/_Q pair persisted.

Function
REQ-012 Q and _Q SHALL each pass through a two-stage synchronizer (s1, s2); all decoding SHALL use the s2 values only.
REQ-013 The s2 pair SHALL decode as follows: (1,0) = valid-high; (0,1) = valid-low; (0,0) or (1,1) = invalid.
REQ-014 The FSM SHALL have three states, LOW, HIGH and BAD, and SHALL hold a 1-bit invalid-pending flag, inv_p.
REQ-015 LOW SHALL go to HIGH on valid-high, asserting Rise for exactly the following cycle.
REQ-016 HIGH SHALL go to LOW on valid-low, asserting Fall for exactly the following cycle.
REQ-017 A valid pair equal to the current state SHALL hold the state and produce no pulse.
REQ-018 An invalid pair with inv_p=0 SHALL set inv_p and keep the state unchanged, so that a single-cycle invalid pair is tolerated as transition skew.
REQ-019 An invalid pair with inv_p=1 SHALL move the FSM to BAD and set Fault.
REQ-020 Any valid pair SHALL clear inv_p.
REQ-021 In BAD, two consecutive valid pairs SHALL move the FSM to LOW or HIGH per the second pair, with no Rise or Fall generated on exit from BAD.
REQ-022 In BAD, a single valid pair followed by an invalid pair SHALL keep the FSM in BAD.
REQ-023 Qs SHALL be 1 in HIGH and 0 in LOW, and SHALL hold its last value while in BAD.
REQ-024 Latency: a clean input change before edge E1 SHALL be captured by s1 at E1 and by s2 at E2, with state, Qs and Rise/Fall registered at E3; the pulse SHALL be high between E3 and E4.
REQ-025 Cnt SHALL increment by 1 on each cycle in which the Rise pulse is issued (the same edge that registers Rise).
REQ-026 Cnt SHALL wrap from 15 to 0, and that wrap SHALL set Ovf.
REQ-027 CntClr=1 SHALL set Cnt=0 and Ovf=0 at the next edge.
REQ-028 If CntClr and an increment coincide, Cnt SHALL become 1 and Ovf SHALL become 0.
REQ-029 Fault SHALL be cleared only by _CLR; CntClr SHALL have no effect on Fault.
REQ-030 Rise and Fall SHALL never be asserted in the same cycle.

Reset
REQ-031 When _CLR=0 at a rising edge of Cp, the block SHALL set s1 = s2 = (Q=0, _Q=1), state = LOW, inv_p = 0, Qs = 0, Rise = 0, Fall = 0, Cnt = 0, Ovf = 0 and Fault = 0.
REQ-032 _CLR SHALL take priority over CntClr and over all FSM activity, including reset asserted mid-pulse or mid-BAD, and all outputs SHALL read reset values the cycle after that edge.
REQ-033 After _CLR returns to 1, an input already at (1,0) SHALL produce Rise at E3 per REQ-024.

Verification
REQ-034 The bench SHALL cover: reset, then (Q,_Q)=(1,0) before E1 -> Rise=1 only between E3 and E4, Qs=1 from E3, Cnt=1.
REQ-035 The bench SHALL cover: from HIGH, drive (0,1) -> Fall for one cycle, Qs=0, Cnt unchanged at 1, Rise=0 throughout.
REQ-036 The bench SHALL cover: from LOW, drive (1,1) for 1 cycle then (0,1) -> no Fault, no pulse; then drive (1,1) for 3 cycles -> Fault=1, state BAD, Qs stays 0.
REQ-037 The bench SHALL cover: from BAD, drive (1,0) for 2+ cycles -> state HIGH, Qs=1, Rise=0, Fault stays 1.
REQ-038 The bench SHALL cover: 16 clean rise/fall cycles from Cnt=0 -> Cnt=0, Ovf=1; then CntClr coincident with a Rise -> Cnt=1, Ovf=0.
REQ-039 The bench SHALL cover: _CLR=0 while in HIGH with Cnt=5 and Fault=1 -> next cycle all outputs 0.
